// File: rtl/fifo_sched_pkg.sv
// Shared state encoding and counter-width helper for the FIFO burst scheduler.
package fifo_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } sched_state_t;

  // Bits needed to count 0..value-1; never returns less than one bit.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    if (result < 1) begin
      result = 1;
    end else begin
      result = result;
    end
    return result;
  endfunction

endpackage

// File: rtl/fifo_level_calc.sv
// Turns the FIFO's wrapping usedw plus its full flag into a true fill level.
module fifo_level_calc
  import fifo_sched_pkg::*;
#(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          fifo_full,
  input  logic [AW-1:0] fifo_usedw,
  output logic [AW:0]   level
);

  localparam int LVL_W = AW + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  // usedw reads zero when the FIFO is full, so full overrides it
  always_comb begin
    if (fifo_full) begin
      level = FULL_LVL;
    end else begin
      level = {1'b0, fifo_usedw};
    end
  end

endmodule

// File: rtl/fifo_burst_sched.sv
// Accepts upstream writes into an scfifo and drains it downstream in framed bursts
// separated by an idle gap; a flush pauses intake and pushes out the residue.
module fifo_burst_sched
  import fifo_sched_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 256,
  parameter int AW        = 8,
  parameter int BURST_LEN = 16,
  parameter int GAP_CYC   = 4
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic              fifo_wr_req,
  output logic [DATA_W-1:0] fifo_wr_data,
  output logic              fifo_rd_req,
  input  logic [DATA_W-1:0] fifo_q,
  input  logic              fifo_full,
  input  logic              fifo_empty,
  input  logic [AW-1:0]     fifo_usedw,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  output logic              out_sop,
  output logic              out_eop,
  output logic              busy,
  output logic              rd_err
);

  localparam int LVL_W = AW + 1;
  localparam int CNT_W = clog2(BURST_LEN + 1);
  localparam int GAP_W = clog2(GAP_CYC + 1);
  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BURST_CNT = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [GAP_W-1:0] GAP_ONE   = GAP_W'(1);
  localparam logic [GAP_W-1:0] GAP_LAST  = GAP_W'(GAP_CYC - 1);

  sched_state_t     state_r;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] len_r;
  logic [GAP_W-1:0] gap_r;
  logic             rd_req_r;
  logic             flush_pend_r;
  logic             run_r;
  logic             out_valid_r;
  logic             out_sop_r;
  logic             out_eop_r;
  logic             rd_err_r;
  logic [LVL_W-1:0] level_s;
  logic             in_ready_s;

  fifo_level_calc #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_level (
    .fifo_full  (fifo_full),
    .fifo_usedw (fifo_usedw),
    .level      (level_s)
  );

  // run_r keeps intake closed until the first clock after reset release
  assign in_ready_s   = run_r & ~fifo_full & ~flush_pend_r;
  assign in_ready     = in_ready_s;
  assign fifo_wr_req  = in_valid & in_ready_s;
  assign fifo_wr_data = in_data;
  assign fifo_rd_req  = rd_req_r;
  assign out_data     = fifo_q;
  assign out_valid    = out_valid_r;
  assign out_sop      = out_sop_r;
  assign out_eop      = out_eop_r;
  assign rd_err       = rd_err_r;
  assign busy         = (state_r != ST_IDLE) | flush_pend_r | out_valid_r;

  // Intake enable after reset release
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      run_r <= 1'b0;
    end else begin
      run_r <= 1'b1;
    end
  end

  // Flush request: a new pulse wins over the drained-and-idle clear
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      flush_pend_r <= 1'b0;
    end else if (flush) begin
      flush_pend_r <= 1'b1;
    end else if ((state_r == ST_IDLE) && fifo_empty && !out_valid_r) begin
      flush_pend_r <= 1'b0;
    end
  end

  // Burst sequencer; len is frozen at burst start so later writes cannot change it
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= ST_IDLE;
      cnt_r    <= '0;
      len_r    <= '0;
      gap_r    <= '0;
      rd_req_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (level_s >= BURST_LVL) begin
            len_r    <= BURST_CNT;
            cnt_r    <= CNT_ONE;
            rd_req_r <= 1'b1;
            state_r  <= ST_BURST;
          end else if (flush_pend_r && !fifo_empty) begin
            len_r    <= level_s[CNT_W-1:0];
            cnt_r    <= CNT_ONE;
            rd_req_r <= 1'b1;
            state_r  <= ST_BURST;
          end
        end
        ST_BURST: begin
          if (cnt_r == len_r) begin
            rd_req_r <= 1'b0;
            cnt_r    <= '0;
            gap_r    <= '0;
            state_r  <= (GAP_CYC == 0) ? ST_IDLE : ST_GAP;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        ST_GAP: begin
          if (gap_r == GAP_LAST) begin
            state_r <= ST_IDLE;
          end else begin
            gap_r <= gap_r + GAP_ONE;
          end
        end
        default: begin
          state_r  <= ST_IDLE;
          rd_req_r <= 1'b0;
        end
      endcase
    end
  end

  // Output framing follows the FIFO's one-cycle q latency
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      out_valid_r <= 1'b0;
      out_sop_r   <= 1'b0;
      out_eop_r   <= 1'b0;
    end else begin
      out_valid_r <= rd_req_r;
      out_sop_r   <= rd_req_r & (cnt_r == CNT_ONE);
      out_eop_r   <= rd_req_r & (cnt_r == len_r);
    end
  end

  // Sticky read-underflow flag
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      rd_err_r <= 1'b0;
    end else if (rd_req_r && fifo_empty) begin
      rd_err_r <= 1'b1;
    end
  end

endmodule

// File: tb/tb_fifo_burst_sched.sv
// Self-checking bench: scfifo model, data scoreboard, burst-framing rules, table and random stimulus.
module tb_fifo_burst_sched;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 256;
  localparam int AW        = 8;
  localparam int BURST_LEN = 16;
  localparam int GAP_CYC   = 4;

  logic              sys_clk;
  logic              sys_rst_n;
  logic [DATA_W-1:0] in_data;
  logic              in_valid;
  logic              in_ready;
  logic              flush;
  logic              fifo_wr_req;
  logic [DATA_W-1:0] fifo_wr_data;
  logic              fifo_rd_req;
  logic [DATA_W-1:0] fifo_q;
  logic              fifo_full;
  logic              fifo_empty;
  logic [AW-1:0]     fifo_usedw;
  logic [DATA_W-1:0] out_data;
  logic              out_valid;
  logic              out_sop;
  logic              out_eop;
  logic              busy;
  logic              rd_err;

  fifo_burst_sched #(
    .DATA_W(DATA_W), .DEPTH(DEPTH), .AW(AW), .BURST_LEN(BURST_LEN), .GAP_CYC(GAP_CYC)
  ) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .flush(flush), .fifo_wr_req(fifo_wr_req), .fifo_wr_data(fifo_wr_data),
    .fifo_rd_req(fifo_rd_req), .fifo_q(fifo_q), .fifo_full(fifo_full), .fifo_empty(fifo_empty),
    .fifo_usedw(fifo_usedw), .out_data(out_data), .out_valid(out_valid), .out_sop(out_sop),
    .out_eop(out_eop), .busy(busy), .rd_err(rd_err)
  );

  initial sys_clk = 1'b0;
  always #5 sys_clk = ~sys_clk;

  // scfifo model: registered q, usedw wraps to 0 at full, cleared by reset
  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       m_cnt;
  logic [AW-1:0]     m_rp, m_wp;
  logic [DATA_W-1:0] m_q;
  logic              m_do_wr, m_do_rd;

  assign m_do_wr    = fifo_wr_req && (m_cnt < (AW+1)'(DEPTH));
  assign m_do_rd    = fifo_rd_req && (m_cnt != '0);
  assign fifo_full  = (m_cnt == (AW+1)'(DEPTH));
  assign fifo_empty = (m_cnt == '0);
  assign fifo_usedw = m_cnt[AW-1:0];
  assign fifo_q     = m_q;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_cnt <= '0; m_rp <= '0; m_wp <= '0; m_q <= '0;
    end else begin
      if (m_do_wr) begin mem[m_wp] <= fifo_wr_data; m_wp <= m_wp + 1'b1; end
      if (m_do_rd) begin m_q <= mem[m_rp]; m_rp <= m_rp + 1'b1; end
      case ({m_do_wr, m_do_rd})
        2'b10:   m_cnt <= m_cnt + 1'b1;
        2'b01:   m_cnt <= m_cnt - 1'b1;
        default: m_cnt <= m_cnt;
      endcase
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor state
  logic [DATA_W-1:0] sb[$];
  int blen, idle_run, burst_cnt, last_len, full_run, max_full_run;
  bit in_burst, had_burst, flush_armed, full_seen, prev_valid, prev_eop;
  bit smp_rd, smp_ready, smp_busy, smp_valid, smp_acc;

  task automatic mon_reset();
    sb.delete();
    in_burst = 0; had_burst = 0; flush_armed = 0; prev_valid = 0; prev_eop = 0;
    idle_run = 0; blen = 0; full_run = 0;
  endtask

  // Per-cycle checks at the falling edge
  task automatic mon();
    smp_rd = fifo_rd_req; smp_ready = in_ready; smp_busy = busy;
    smp_valid = out_valid; smp_acc = fifo_wr_req;
    if (sys_rst_n) begin
      chk("wr_req", fifo_wr_req, in_valid & in_ready);
      if (fifo_wr_req) sb.push_back(fifo_wr_data);
      chk("rd_on_empty", fifo_rd_req & fifo_empty, 0);
      if (fifo_full) begin
        full_seen = 1; full_run++;
        chk("full_blocks", in_ready, 0);
      end else full_run = 0;
      if (full_run > max_full_run) max_full_run = full_run;
      if (flush) flush_armed = 1;
      if (out_valid) begin
        chk("sop", out_sop, !in_burst);
        if (!in_burst) begin
          if (had_burst) chk("gap", idle_run >= GAP_CYC, 1);
          blen = 0;
        end
        blen++;
        chk("sb_nonempty", sb.size() > 0, 1);
        if (sb.size() > 0) chk("data", out_data, sb.pop_front());
        if (out_eop) begin
          chk("burst_len", (blen == BURST_LEN) || (flush_armed && blen < BURST_LEN), 1);
          if (blen < BURST_LEN) flush_armed = 0;
          last_len = blen; burst_cnt++; in_burst = 0; had_burst = 1; idle_run = 0;
        end else in_burst = 1;
      end else begin
        if (prev_valid) chk("run_ends_eop", prev_eop, 1);
        in_burst = 0;
        idle_run++;
      end
      prev_valid = out_valid; prev_eop = out_eop;
      if (!busy && fifo_empty && !out_valid && !flush) flush_armed = 0;
    end
  endtask

  task automatic cyc();
    @(negedge sys_clk);
    mon();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic wait_quiet(input string nm);
    int q;
    q = 0;
    for (int k = 0; k < 3000 && q < 10; k++) begin
      cyc();
      q = smp_busy ? 0 : q + 1;
    end
    chk({nm, "_quiet"}, q >= 10, 1);
  endtask

  typedef struct {
    int n;
    int exp_pre;
    int exp_res;
  } vec_t;
  vec_t vecs[7];

  logic [DATA_W-1:0] dcnt;
  int n, b0, nrd;
  bit seen;

  initial begin
    vecs[0] = '{n: 15, exp_pre: 0, exp_res: 15};
    vecs[1] = '{n: 16, exp_pre: 1, exp_res: 0};
    vecs[2] = '{n: 17, exp_pre: 1, exp_res: 1};
    vecs[3] = '{n: 33, exp_pre: 2, exp_res: 1};
    vecs[4] = '{n: 5,  exp_pre: 0, exp_res: 5};
    vecs[5] = '{n: 1,  exp_pre: 0, exp_res: 1};
    vecs[6] = '{n: 47, exp_pre: 2, exp_res: 15};

    in_data = '0; in_valid = 1'b0; flush = 1'b0;
    burst_cnt = 0; last_len = 0; max_full_run = 0; full_seen = 0;
    mon_reset();
    sys_rst_n = 1'b1;
    #1 sys_rst_n = 1'b0;

    // Reset: every output low while held
    repeat (2) begin
      @(negedge sys_clk);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_rd_req", fifo_rd_req, 0);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_sop_eop", {out_sop, out_eop}, 0);
      chk("rst_rd_err", rd_err, 0);
      chk("rst_busy", busy, 0);
    end
    @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    cyc(); cyc();
    chk("ready_after_rst", smp_ready, 1);
    chk("busy_after_rst", smp_busy, 0);

    // 15 bytes: no read; 16th byte: rd_req two cycles later, 16 cycles long
    for (int i = 0; i < 15; i++) begin
      in_valid = 1'b1; in_data = DATA_W'(i); cyc();
    end
    in_valid = 1'b0; seen = 0;
    repeat (6) begin cyc(); seen |= smp_rd; end
    chk("no_rd_below_burst", seen, 0);
    in_valid = 1'b1; in_data = 8'd15; cyc(); in_valid = 1'b0;
    chk("lat_c0", smp_rd, 0);
    cyc(); chk("lat_c1", smp_rd, 0);
    cyc(); chk("lat_c2", smp_rd, 1);
    n = 1;
    for (int k = 0; k < 40; k++) begin
      cyc();
      if (smp_rd) n++;
      else break;
    end
    chk("burst_rd_cycles", n, BURST_LEN);
    seen = 0;
    repeat (GAP_CYC - 1) begin cyc(); seen |= smp_rd; end
    chk("gap_no_rd", seen, 0);
    wait_quiet("first");
    chk("first_len", last_len, BURST_LEN);

    // Flush with the FIFO empty
    b0 = burst_cnt;
    flush = 1'b1; cyc(); flush = 1'b0;
    cyc(); chk("empty_flush_pend", smp_ready, 0);
    seen = smp_valid;
    cyc(); chk("empty_flush_clear", smp_ready, 1);
    chk("empty_flush_busy", smp_busy, 0);
    seen |= smp_valid;
    repeat (5) begin cyc(); seen |= smp_valid; end
    chk("empty_flush_no_valid", seen, 0);

    // Table: n writes, settle, then flush out the residue
    dcnt = 8'h40;
    foreach (vecs[v]) begin
      b0 = burst_cnt;
      for (int i = 0; i < vecs[v].n; i++) begin
        in_valid = 1'b1; in_data = dcnt; dcnt = dcnt + 8'd1; cyc();
      end
      in_valid = 1'b0;
      wait_quiet("pre");
      chk("pre_bursts", burst_cnt - b0, vecs[v].exp_pre);
      b0 = burst_cnt;
      flush = 1'b1; cyc(); flush = 1'b0;
      cyc(); chk("flush_blocks", smp_ready, 0);
      wait_quiet("flush");
      chk("flush_bursts", burst_cnt - b0, (vecs[v].exp_res > 0) ? 1 : 0);
      if (vecs[v].exp_res > 0) chk("flush_len", last_len, vecs[v].exp_res);
      chk("ready_back", smp_ready, 1);
      chk("sb_drained", sb.size(), 0);
    end

    // Random traffic with occasional flush pulses
    for (int k = 0; k < 1500; k++) begin
      in_valid = ($urandom_range(0, 9) < 7);
      in_data  = DATA_W'($urandom);
      flush    = ($urandom_range(0, 79) == 0);
      cyc();
    end
    in_valid = 1'b0; flush = 1'b0;

    // Continuous stream until well past full
    in_valid = 1'b1; in_data = dcnt;
    for (int k = 0; k < 1300; k++) begin
      cyc();
      if (smp_acc) begin dcnt = dcnt + 8'd1; in_data = dcnt; end
    end
    in_valid = 1'b0;
    chk("full_seen", full_seen, 1);
    chk("no_full_stall", max_full_run <= 10, 1);
    flush = 1'b1; cyc(); flush = 1'b0;
    wait_quiet("drain");
    chk("sb_empty_end", sb.size(), 0);
    chk("rd_err_clean", rd_err, 0);

    // Reset in the 7th read cycle of a burst
    for (int i = 0; i < BURST_LEN; i++) begin
      in_valid = 1'b1; in_data = 8'hA0 + DATA_W'(i); cyc();
    end
    in_valid = 1'b0; nrd = 0;
    for (int k = 0; k < 60 && nrd < 6; k++) begin
      cyc();
      if (smp_rd) nrd++;
    end
    chk("beat7_reached", nrd, 6);
    @(negedge sys_clk);
    chk("beat7_rd", fifo_rd_req, 1);
    #1 sys_rst_n = 1'b0;
    #1;
    chk("abort_rd_req", fifo_rd_req, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_busy", busy, 0);
    mon_reset();
    @(posedge sys_clk); @(posedge sys_clk); #1 sys_rst_n = 1'b1;
    seen = 0;
    repeat (12) begin cyc(); seen |= smp_rd; end
    chk("idle_after_abort", seen, 0);
    chk("abort_rd_err", rd_err, 0);
    chk("abort_ready", smp_ready, 1);
    chk("abort_busy_after", smp_busy, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
